// File: rtl/board_pkg.sv
// Shared board geometry, tile encodings and arbiter state type for the board RAM slice.
package board_pkg;

  localparam int BOARD_W     = 32;
  localparam int BOARD_H     = 24;
  localparam int BOARD_TILES = BOARD_W * BOARD_H;
  localparam int TILE_PX     = 20;

  typedef enum logic [3:0] {
    T_EMPTY  = 4'd0,
    T_WALL   = 4'd1,
    T_PELLET = 4'd2,
    T_POWER  = 4'd3,
    T_DOOR   = 4'd4
  } tile_t;

  typedef enum logic [1:0] {
    INIT_RD = 2'd0,
    INIT_WR = 2'd1,
    RUN     = 2'd2
  } arb_state_t;

  // True when a tile address lies past the end of the board.
  function automatic logic tile_oob(input int unsigned addr, input int unsigned depth);
    return (addr >= depth);
  endfunction

endpackage

// File: rtl/board_mem_arbiter_if.sv
// Bus bundle between the board RAM arbiter, its requesters, the initial-board ROM and the RAM.
interface board_mem_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 4
);

  logic          board_reload;
  logic          init_busy;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_valid;
  logic [DW-1:0] vid_data;
  logic          gl_req;
  logic          gl_we;
  logic [AW-1:0] gl_addr;
  logic [DW-1:0] gl_wdata;
  logic          gl_ack;
  logic          gl_rvalid;
  logic [DW-1:0] gl_rdata;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_q;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_q;

  modport slave (
    input  board_reload, vid_req, vid_addr, gl_req, gl_we, gl_addr, gl_wdata, rom_q, ram_q,
    output init_busy, vid_valid, vid_data, gl_ack, gl_rvalid, gl_rdata,
           rom_addr, ram_addr, ram_we, ram_wdata
  );

  modport master (
    output board_reload, vid_req, vid_addr, gl_req, gl_we, gl_addr, gl_wdata, rom_q, ram_q,
    input  init_busy, vid_valid, vid_data, gl_ack, gl_rvalid, gl_rdata,
           rom_addr, ram_addr, ram_we, ram_wdata
  );

endinterface

// File: rtl/board_init_seq.sv
// ROM-to-RAM board copy sequencer: walks the ROM, writes each tile one cycle later, then flags done.
module board_init_seq
  import board_pkg::*;
#(
  parameter int DEPTH = BOARD_TILES,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          restart,
  output logic [AW-1:0] rom_addr,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic          done
);

  arb_state_t    state_r, state_nx;
  logic [AW-1:0] cnt_r, cnt_nx;

  // State and copy counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= INIT_RD;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nx;
      cnt_r   <= cnt_nx;
    end
  end

  // Next-state logic; a restart from any state begins a fresh copy
  always_comb begin
    state_nx = state_r;
    cnt_nx   = cnt_r;
    if (restart) begin
      state_nx = INIT_RD;
      cnt_nx   = '0;
    end else begin
      case (state_r)
        INIT_RD: begin
          if (cnt_r == AW'(DEPTH - 1)) begin
            state_nx = INIT_WR;
          end else begin
            cnt_nx = cnt_r + AW'(1);
          end
        end
        INIT_WR: state_nx = RUN;
        RUN:     state_nx = RUN;
        default: begin
          state_nx = INIT_RD;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  // Outputs: ROM data lags its address by a cycle, so each write targets the previous address
  always_comb begin
    rom_addr = '0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    done     = 1'b0;
    case (state_r)
      INIT_RD: begin
        rom_addr = cnt_r;
        wr_en    = (cnt_r != '0);
        wr_addr  = (cnt_r == '0) ? '0 : (cnt_r - AW'(1));
      end
      INIT_WR: begin
        wr_en   = 1'b1;
        wr_addr = AW'(DEPTH - 1);
      end
      RUN:     done = 1'b1;
      default: done = 1'b0;
    endcase
  end

endmodule

// File: rtl/board_mem_arbiter.sv
// Board RAM owner: copies the ROM after reset/reload, then shares the port with video first.
// Optional BOARD_STARVE_GUARD_EN forces a game-logic grant after STARVE_LIMIT denied cycles.
module board_mem_arbiter
  import board_pkg::*;
#(
  parameter int DEPTH        = BOARD_TILES,
  parameter int AW           = 10,
  parameter int DW           = 4,
  parameter int STARVE_LIMIT = 64
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  board_mem_arbiter_if.slave   bus
);

  logic          init_done_s;
  logic          init_we_s;
  logic [AW-1:0] init_waddr_s;
  logic          force_gl_s;
  logic          vid_grant_s;
  logic          gl_grant_s;
  logic          vid_oob_s;
  logic          gl_oob_s;
  logic [AW-1:0] ram_addr_s;
  logic          ram_we_s;
  logic [DW-1:0] ram_wdata_s;
  logic [AW-1:0] ram_addr_hold_r;
  logic          vid_valid_r;
  logic          vid_oob_r;
  logic          gl_rvalid_r;
  logic          gl_oob_r;

  board_init_seq #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_init_seq (
    .clk      (CLOCK_50),
    .rst      (reset),
    .restart  (bus.board_reload),
    .rom_addr (bus.rom_addr),
    .wr_en    (init_we_s),
    .wr_addr  (init_waddr_s),
    .done     (init_done_s)
  );

  // A reload cycle grants nothing, so no response can land inside the next copy.
  assign vid_grant_s = init_done_s && !bus.board_reload && bus.vid_req && !force_gl_s;
  assign gl_grant_s  = init_done_s && !bus.board_reload && bus.gl_req &&
                       (!bus.vid_req || force_gl_s);
  assign vid_oob_s   = tile_oob(32'(bus.vid_addr), 32'(DEPTH));
  assign gl_oob_s    = tile_oob(32'(bus.gl_addr), 32'(DEPTH));

`ifdef BOARD_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_cnt_r;

  assign force_gl_s = (starve_cnt_r == SW'(STARVE_LIMIT));

  // Counts consecutive RUN cycles in which game logic waits without an ack
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      starve_cnt_r <= '0;
    end else if (!init_done_s || !bus.gl_req || gl_grant_s) begin
      starve_cnt_r <= '0;
    end else if (!force_gl_s) begin
      starve_cnt_r <= starve_cnt_r + SW'(1);
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end
`else
  logic [31:0] starve_unused_s;
  assign starve_unused_s = 32'(STARVE_LIMIT);
  assign force_gl_s      = 1'b0;
`endif

  // RAM port mux: copy sequencer, then video, then game logic; idle holds the address
  always_comb begin
    ram_addr_s  = ram_addr_hold_r;
    ram_we_s    = 1'b0;
    ram_wdata_s = '0;
    if (!init_done_s) begin
      ram_addr_s  = init_waddr_s;
      ram_we_s    = init_we_s;
      ram_wdata_s = init_we_s ? bus.rom_q : '0;
    end else if (vid_grant_s) begin
      ram_addr_s = bus.vid_addr;
    end else if (gl_grant_s) begin
      ram_addr_s  = bus.gl_addr;
      ram_we_s    = bus.gl_we && !gl_oob_s;
      ram_wdata_s = bus.gl_wdata;
    end else begin
      ram_addr_s = ram_addr_hold_r;
    end
  end

  // Response tracking for the one-cycle RAM read latency
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      ram_addr_hold_r <= '0;
      vid_valid_r     <= 1'b0;
      vid_oob_r       <= 1'b0;
      gl_rvalid_r     <= 1'b0;
      gl_oob_r        <= 1'b0;
    end else begin
      ram_addr_hold_r <= ram_addr_s;
      vid_valid_r     <= vid_grant_s;
      vid_oob_r       <= vid_grant_s && vid_oob_s;
      gl_rvalid_r     <= gl_grant_s && !bus.gl_we;
      gl_oob_r        <= gl_grant_s && gl_oob_s;
    end
  end

  assign bus.ram_addr  = ram_addr_s;
  assign bus.ram_we    = ram_we_s;
  assign bus.ram_wdata = ram_wdata_s;
  assign bus.init_busy = !init_done_s;
  assign bus.gl_ack    = gl_grant_s;
  assign bus.vid_valid = vid_valid_r;
  assign bus.gl_rvalid = gl_rvalid_r;
  // Off-board reads return an empty tile rather than whatever the RAM produced
  assign bus.vid_data  = (vid_valid_r && !vid_oob_r) ? bus.ram_q : '0;
  assign bus.gl_rdata  = (gl_rvalid_r && !gl_oob_r) ? bus.ram_q : '0;

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Directed self-checking bench for board_mem_arbiter with behavioural ROM (i%5) and write-first RAM.
module tb_board_mem_arbiter;
  import board_pkg::*;

  logic CLOCK_50;
  logic reset;
  int   errors;
  int   checks;

  board_mem_arbiter_if #(.AW(10), .DW(4)) bus ();

  board_mem_arbiter #(
    .DEPTH        (768),
    .AW           (10),
    .DW           (4),
    .STARVE_LIMIT (64)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  logic [3:0] ram_mem [0:767];

  // Write-first RAM and ROM models, both with one cycle of read latency
  always @(posedge CLOCK_50) begin
    if (bus.ram_we && bus.ram_addr < 10'd768) ram_mem[bus.ram_addr] <= bus.ram_wdata;
    if (bus.ram_we) bus.ram_q <= bus.ram_wdata;
    else if (bus.ram_addr >= 10'd768) bus.ram_q <= 4'hA;
    else bus.ram_q <= ram_mem[bus.ram_addr];
    bus.rom_q <= 4'(bus.rom_addr % 10'd5);
  end

  task automatic test_reset();
    reset = 1'b1;
    bus.board_reload = 1'b0;
    bus.vid_req = 1'b0; bus.vid_addr = 10'd0;
    bus.gl_req = 1'b0; bus.gl_we = 1'b0; bus.gl_addr = 10'd0; bus.gl_wdata = 4'd0;
    repeat (2) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    checks++; if (bus.init_busy !== 1'b1) begin errors++; $display("FAIL rst_init_busy: got %0b exp 1", bus.init_busy); end
    checks++; if (bus.vid_valid !== 1'b0) begin errors++; $display("FAIL rst_vid_valid: got %0b exp 0", bus.vid_valid); end
    checks++; if (bus.vid_data !== 4'd0) begin errors++; $display("FAIL rst_vid_data: got %0h exp 0", bus.vid_data); end
    checks++; if (bus.gl_ack !== 1'b0) begin errors++; $display("FAIL rst_gl_ack: got %0b exp 0", bus.gl_ack); end
    checks++; if (bus.gl_rvalid !== 1'b0) begin errors++; $display("FAIL rst_gl_rvalid: got %0b exp 0", bus.gl_rvalid); end
    checks++; if (bus.gl_rdata !== 4'd0) begin errors++; $display("FAIL rst_gl_rdata: got %0h exp 0", bus.gl_rdata); end
    checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL rst_ram_we: got %0b exp 0", bus.ram_we); end
    checks++; if (bus.rom_addr !== 10'd0) begin errors++; $display("FAIL rst_rom_addr: got %0d exp 0", bus.rom_addr); end
  endtask

  task automatic test_init_copy();
    int busy = 0;
    int vv = 0;
    int ack = 0;
    int bad = 0;
    @(posedge CLOCK_50); #1;
    reset = 1'b0;
    bus.vid_req = 1'b1; bus.vid_addr = 10'd3;
    bus.gl_req = 1'b1; bus.gl_we = 1'b0; bus.gl_addr = 10'd7;
    for (int i = 0; i < 2000; i++) begin
      @(negedge CLOCK_50);
      if (bus.vid_valid) vv++;
      if (bus.gl_ack) ack++;
      if (!bus.init_busy) break;
      busy++;
      if (busy == 700) begin bus.vid_req = 1'b0; bus.gl_req = 1'b0; end
    end
    checks++; if (busy !== 769) begin errors++; $display("FAIL init_busy_cycles: got %0d exp 769", busy); end
    checks++; if (vv !== 0) begin errors++; $display("FAIL init_vid_valid: got %0d exp 0", vv); end
    checks++; if (ack !== 0) begin errors++; $display("FAIL init_gl_ack: got %0d exp 0", ack); end
    for (int i = 0; i < 768; i++) if (ram_mem[i] !== 4'(i % 5)) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL init_ram_content: got %0d bad tiles exp 0", bad); end
  endtask

  task automatic test_priority();
    @(posedge CLOCK_50); #1;
    bus.vid_req = 1'b1; bus.vid_addr = 10'd33;
    bus.gl_req = 1'b1; bus.gl_we = 1'b1; bus.gl_addr = 10'd40; bus.gl_wdata = 4'd2;
    @(negedge CLOCK_50);
    checks++; if (bus.gl_ack !== 1'b0) begin errors++; $display("FAIL prio_no_ack: got %0b exp 0", bus.gl_ack); end
    checks++; if (bus.ram_addr !== 10'd33) begin errors++; $display("FAIL prio_vid_addr: got %0d exp 33", bus.ram_addr); end
    checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL prio_vid_we: got %0b exp 0", bus.ram_we); end
    @(posedge CLOCK_50); #1;
    bus.vid_req = 1'b0;
    @(negedge CLOCK_50);
    checks++; if (bus.vid_valid !== 1'b1) begin errors++; $display("FAIL prio_vid_valid: got %0b exp 1", bus.vid_valid); end
    checks++; if (bus.vid_data !== 4'd3) begin errors++; $display("FAIL prio_vid_data: got %0h exp 3", bus.vid_data); end
    checks++; if (bus.gl_ack !== 1'b1) begin errors++; $display("FAIL prio_gl_ack: got %0b exp 1", bus.gl_ack); end
    checks++; if (bus.ram_we !== 1'b1 || bus.ram_addr !== 10'd40 || bus.ram_wdata !== 4'd2) begin
      errors++; $display("FAIL prio_gl_write: got we=%0b addr=%0d data=%0h exp 1/40/2", bus.ram_we, bus.ram_addr, bus.ram_wdata); end
    @(posedge CLOCK_50); #1;
    bus.gl_we = 1'b0;
    @(negedge CLOCK_50);
    checks++; if (bus.gl_ack !== 1'b1) begin errors++; $display("FAIL b2b_gl_ack: got %0b exp 1", bus.gl_ack); end
    checks++; if (bus.vid_valid !== 1'b0) begin errors++; $display("FAIL b2b_vid_valid: got %0b exp 0", bus.vid_valid); end
    @(posedge CLOCK_50); #1;
    bus.gl_req = 1'b0;
    @(negedge CLOCK_50);
    checks++; if (bus.gl_rvalid !== 1'b1) begin errors++; $display("FAIL b2b_gl_rvalid: got %0b exp 1", bus.gl_rvalid); end
    checks++; if (bus.gl_rdata !== 4'd2) begin errors++; $display("FAIL b2b_gl_rdata: got %0h exp 2", bus.gl_rdata); end
    checks++; if (bus.gl_ack !== 1'b0) begin errors++; $display("FAIL b2b_ack_drop: got %0b exp 0", bus.gl_ack); end
  endtask

  task automatic test_read_after_write();
    logic [9:0] raw_addr [2];
    logic [3:0] raw_data [2];
    raw_addr[0] = 10'd100; raw_data[0] = T_EMPTY;
    raw_addr[1] = 10'd101; raw_data[1] = T_DOOR;
    for (int v = 0; v < 2; v++) begin
      @(posedge CLOCK_50); #1;
      bus.gl_req = 1'b1; bus.gl_we = 1'b1; bus.gl_addr = raw_addr[v]; bus.gl_wdata = raw_data[v];
      @(negedge CLOCK_50);
      checks++; if (bus.gl_ack !== 1'b1) begin errors++; $display("FAIL raw_wr_ack[%0d]: got %0b exp 1", v, bus.gl_ack); end
      @(posedge CLOCK_50); #1;
      bus.gl_we = 1'b0;
      @(negedge CLOCK_50);
      checks++; if (bus.gl_ack !== 1'b1) begin errors++; $display("FAIL raw_rd_ack[%0d]: got %0b exp 1", v, bus.gl_ack); end
      @(posedge CLOCK_50); #1;
      bus.gl_req = 1'b0;
      @(negedge CLOCK_50);
      checks++; if (bus.gl_rvalid !== 1'b1) begin errors++; $display("FAIL raw_rvalid[%0d]: got %0b exp 1", v, bus.gl_rvalid); end
      checks++; if (bus.gl_rdata !== raw_data[v]) begin errors++; $display("FAIL raw_rdata[%0d]: got %0h exp %0h", v, bus.gl_rdata, raw_data[v]); end
    end
  endtask

  task automatic test_out_of_range();
    int we_seen = 0;
    @(posedge CLOCK_50); #1;
    bus.vid_req = 1'b1; bus.vid_addr = 10'd800;
    bus.gl_req = 1'b1; bus.gl_we = 1'b1; bus.gl_addr = 10'd900; bus.gl_wdata = 4'd3;
    @(negedge CLOCK_50);
    if (bus.ram_we) we_seen++;
    checks++; if (bus.ram_addr !== 10'd800) begin errors++; $display("FAIL oor_vid_addr: got %0d exp 800", bus.ram_addr); end
    @(posedge CLOCK_50); #1;
    bus.vid_req = 1'b0;
    @(negedge CLOCK_50);
    if (bus.ram_we) we_seen++;
    checks++; if (bus.vid_valid !== 1'b1) begin errors++; $display("FAIL oor_vid_valid: got %0b exp 1", bus.vid_valid); end
    checks++; if (bus.vid_data !== 4'd0) begin errors++; $display("FAIL oor_vid_data: got %0h exp 0", bus.vid_data); end
    checks++; if (bus.gl_ack !== 1'b1) begin errors++; $display("FAIL oor_wr_ack: got %0b exp 1", bus.gl_ack); end
    @(posedge CLOCK_50); #1;
    bus.gl_we = 1'b0;
    @(negedge CLOCK_50);
    if (bus.ram_we) we_seen++;
    checks++; if (bus.gl_ack !== 1'b1) begin errors++; $display("FAIL oor_rd_ack: got %0b exp 1", bus.gl_ack); end
    @(posedge CLOCK_50); #1;
    bus.gl_req = 1'b0;
    @(negedge CLOCK_50);
    if (bus.ram_we) we_seen++;
    checks++; if (bus.gl_rvalid !== 1'b1 || bus.gl_rdata !== 4'd0) begin
      errors++; $display("FAIL oor_rd_data: got rvalid=%0b data=%0h exp 1/0", bus.gl_rvalid, bus.gl_rdata); end
    checks++; if (we_seen !== 0) begin errors++; $display("FAIL oor_ram_we: got %0d write cycles exp 0", we_seen); end
  endtask

  task automatic test_reload();
    int busy = 0;
    @(posedge CLOCK_50); #1;
    bus.gl_req = 1'b1; bus.gl_we = 1'b1; bus.gl_addr = 10'd12; bus.gl_wdata = 4'd4;
    @(negedge CLOCK_50);
    checks++; if (bus.gl_ack !== 1'b1) begin errors++; $display("FAIL rl_wr_ack: got %0b exp 1", bus.gl_ack); end
    @(posedge CLOCK_50); #1;
    bus.gl_req = 1'b0; bus.vid_req = 1'b1; bus.vid_addr = 10'd14;
    @(posedge CLOCK_50); #1;
    bus.vid_req = 1'b0; bus.board_reload = 1'b1;
    @(negedge CLOCK_50);
    checks++; if (bus.vid_valid !== 1'b1 || bus.vid_data !== 4'd4) begin
      errors++; $display("FAIL rl_pending_vid: got valid=%0b data=%0h exp 1/4", bus.vid_valid, bus.vid_data); end
    checks++; if (ram_mem[12] !== 4'd4) begin errors++; $display("FAIL rl_game_write: got %0h exp 4", ram_mem[12]); end
    @(posedge CLOCK_50); #1;
    bus.board_reload = 1'b0;
    repeat (300) @(posedge CLOCK_50);
    #1;
    bus.board_reload = 1'b1;
    @(posedge CLOCK_50); #1;
    bus.board_reload = 1'b0;
    @(negedge CLOCK_50);
    checks++; if (bus.rom_addr !== 10'd0) begin errors++; $display("FAIL rl_restart_addr: got %0d exp 0", bus.rom_addr); end
    for (int i = 0; i < 2000; i++) begin
      if (!bus.init_busy) break;
      busy++;
      @(negedge CLOCK_50);
    end
    checks++; if (busy !== 769) begin errors++; $display("FAIL rl_busy_cycles: got %0d exp 769", busy); end
    checks++; if (ram_mem[12] !== 4'd2) begin errors++; $display("FAIL rl_overwrite: got %0h exp 2", ram_mem[12]); end
  endtask

  task automatic test_starve();
    int ack_at = 0;
    int exp_ack;
    logic exp_vv;
    logic exp_rv;
`ifdef BOARD_STARVE_GUARD_EN
    exp_ack = 65; exp_vv = 1'b0; exp_rv = 1'b1;
`else
    exp_ack = 0; exp_vv = 1'b1; exp_rv = 1'b0;
`endif
    @(posedge CLOCK_50); #1;
    bus.vid_req = 1'b1; bus.vid_addr = 10'd0;
    bus.gl_req = 1'b1; bus.gl_we = 1'b0; bus.gl_addr = 10'd5;
    for (int i = 1; i <= 1000; i++) begin
      @(negedge CLOCK_50);
      if (bus.gl_ack) begin ack_at = i; break; end
    end
    checks++; if (ack_at !== exp_ack) begin errors++; $display("FAIL starve_ack_cycle: got %0d exp %0d", ack_at, exp_ack); end
    @(posedge CLOCK_50); #1;
    bus.gl_req = 1'b0;
    @(negedge CLOCK_50);
    checks++; if (bus.vid_valid !== exp_vv) begin errors++; $display("FAIL starve_vid_valid: got %0b exp %0b", bus.vid_valid, exp_vv); end
    checks++; if (bus.gl_rvalid !== exp_rv) begin errors++; $display("FAIL starve_gl_rvalid: got %0b exp %0b", bus.gl_rvalid, exp_rv); end
    @(posedge CLOCK_50); #1;
    bus.vid_req = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_init_copy();
    test_priority();
    test_read_after_write();
    test_out_of_range();
    test_reload();
    test_starve();
    repeat (2) @(posedge CLOCK_50);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/board_mem_arbiter.md
Name: board_mem_arbiter

Overview:
- Owns the single-port writable board RAM: 768 tiles, 4-bit tile type each, addressed as block_y*32+block_x.
- After reset, and on a level reload, copies the initial board ROM into the RAM.
- Once the copy is done, shares the RAM port between two requesters:
  - the VGA tile renderer, which has fixed priority;
  - game logic (pellet eating, tile queries), which uses a req/ack handshake.

Parameters:
- DEPTH, 768: number of board tiles.
- AW, 10: address width.
- DW, 4: tile type width.
- STARVE_LIMIT, 64: consecutive denied game-logic cycles before a forced grant (used only with the optional feature).

Ports:
- CLOCK_50  in  1  sole clock.
- reset  in  1  asynchronous, active-high.
- board_reload  in  1  one-cycle pulse; restarts the ROM→RAM copy.
- init_busy  out  1  high while the copy is in progress.
- vid_req  in  1  renderer read request.
- vid_addr  in  AW  renderer tile address.
- vid_valid  out  1  vid_data valid.
- vid_data  out  DW  tile type returned to the renderer.
- gl_req  in  1  game-logic request; held until ack.
- gl_we  in  1  1 = write, 0 = read.
- gl_addr  in  AW  game-logic address.
- gl_wdata  in  DW  write data.
- gl_ack  out  1  one-cycle grant pulse.
- gl_rvalid  out  1  read data valid.
- gl_rdata  out  DW  read data.
- rom_addr  out  AW  initial-board ROM address.
- rom_q  in  DW  ROM data, 1-cycle registered latency.
- ram_addr  out  AW  board RAM address.
- ram_we  out  1  RAM write enable.
- ram_wdata  out  DW  RAM write data.
- ram_q  in  DW  RAM data, 1-cycle registered latency.

Behaviour:
- Reset (asynchronous): state=INIT_RD, cnt=0, init_busy=1. All other outputs are 0, including vid_valid, gl_ack, gl_rvalid, vid_data, gl_rdata and ram_we.
- INIT_RD, cycle k for k=0..DEPTH-1:
  - rom_addr=k.
  - For k≥1: ram_we=1, ram_addr=k-1, ram_wdata=rom_q.
  - After k=DEPTH-1, go to INIT_WR.
- INIT_WR: writes the last tile (ram_addr=DEPTH-1), then goes to RUN. init_busy falls on entry to RUN.
- Copy length: exactly DEPTH+1 cycles from reset release.
- During INIT:
  - vid_req is ignored; vid_valid=0 and vid_data=0, which the renderer draws as an empty tile.
  - gl_req is never acked.
- board_reload:
  - In RUN: next state INIT_RD, cnt=0.
  - In INIT: restarts from cnt=0.
  - A read granted in the cycle before the reload still returns its valid response one cycle later.
- RUN, per cycle, with video priority:
  - If vid_req=1: ram_addr=vid_addr, ram_we=0. Next cycle: vid_valid=1, vid_data=ram_q.
  - Else if gl_req=1: gl_ack=1 this cycle, ram_addr=gl_addr, ram_we=gl_we, ram_wdata=gl_wdata. If it is a read, next cycle gl_rvalid=1 and gl_rdata=ram_q.
  - Else: ram_we=0, ram_addr holds its last value.
- Latency: 1 cycle from grant to read data. vid_valid is 0 on any cycle not following a granted video read.
- Handshake:
  - gl_addr, gl_we and gl_wdata must stay stable while gl_req=1 and gl_ack=0.
  - gl_ack is never asserted on two consecutive cycles for one transaction; the requester deasserts gl_req or presents the next transaction after the ack.
  - Back-to-back grants are legal when gl_req stays high with new data.
- Out-of-range address (≥DEPTH):
  - Video read: vid_valid=1, vid_data=0, RAM not driven with a write.
  - Game write: acked, ram_we forced to 0.
  - Game read: acked, gl_rdata=0.
- Read-after-write: a game read granted the cycle after a write to the same address returns the new value; the RAM is write-first.

Optional Feature:
- Macro: BOARD_STARVE_GUARD_EN.
- Defined:
  - A counter increments each RUN cycle in which gl_req=1 and no ack is given; it resets on ack or when gl_req=0.
  - When the counter reaches STARVE_LIMIT, game logic is granted that cycle regardless of vid_req.
  - The video request is dropped: vid_valid=0 the next cycle.
- Not defined: strict video priority; game logic can starve indefinitely.

Decomposition:
- board_pkg holds:
  - BOARD_W=32, BOARD_H=24, BOARD_TILES=768, TILE_PX=20;
  - tile_t, a 4-bit enum (T_EMPTY=0, T_WALL, T_PELLET, T_POWER, T_DOOR);
  - the state enum arb_state_t {INIT_RD, INIT_WR, RUN}.
- One sub-module: board_init_seq, which holds the copy counter and the INIT_RD/INIT_WR FSM and outputs rom_addr, the copy write port and done.

Test Plan:
- Release reset, ROM[i]=i%5:
  - init_busy=1 for exactly 769 cycles.
  - RAM[0..767]=i%5.
  - vid_valid stays 0 throughout.
- RUN, vid_req=1 with addr=33 while gl_req=1 is a write of 2 to addr 40:
  - vid_data=RAM[33] one cycle later.
  - gl_ack only on the first cycle where vid_req=0.
  - A subsequent read of 40 returns 2.
- Game write of T_EMPTY to addr 100, then a read of 100 on the next cycle:
  - gl_rvalid=1 with gl_rdata=0 one cycle after the second ack.
- Video read of addr 800, and game write to 900:
  - vid_data=0 with vid_valid=1.
  - Write acked, ram_we never high.
- board_reload pulsed at init cycle 300:
  - Copy restarts at cnt=0; init_busy low 769 cycles after the pulse.
  - A game write made before the reload is overwritten by the ROM value.
- With BOARD_STARVE_GUARD_EN, STARVE_LIMIT=64, vid_req held at 1 and gl_req=1:
  - gl_ack on the 65th cycle; vid_valid=0 on the following cycle.
  - Without the macro, no ack is given during 1000 cycles.
